// File: rtl/ooo_pkg.sv
// ============================================================================
// ooo_pkg : shared types and sizes for the out-of-order core
// Revision: 1.0
// ============================================================================
`default_nettype none

package ooo_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
    localparam int PREG_W    = 7;
    localparam int PC_W      = 9;

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [4:0]        rd;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] old_prd;
        logic              regwrite;
    } rob_entry_t;

endpackage

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ============================================================================
// reorder_buffer : in-order retirement queue with completion tracking and
//                  branch-mispredict flush of younger entries
// Revision: 1.0
// ============================================================================
`default_nettype none

module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int PREG_W = 7,
    parameter int PC_W   = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    output logic [$clog2(DEPTH)-1:0] alloc_tag,
    input  logic [PC_W-1:0]          alloc_pc,
    input  logic [4:0]               alloc_rd,
    input  logic [PREG_W-1:0]        alloc_prd,
    input  logic [PREG_W-1:0]        alloc_old_prd,
    input  logic                     alloc_regwrite,
    input  logic                     cmpl_valid,
    input  logic [$clog2(DEPTH)-1:0] cmpl_tag,
    input  logic                     flush_valid,
    input  logic [$clog2(DEPTH)-1:0] flush_tag,
    output logic                     commit_en,
    output logic [PREG_W-1:0]        commit_old_preg,
    output logic [PREG_W-1:0]        commit_prd,
    output logic [4:0]               commit_rd,
    output logic                     commit_regwrite,
    output logic [PC_W-1:0]          commit_pc,
    output logic                     empty
);

    import ooo_pkg::rob_entry_t;

    localparam int TAG_W = $clog2(DEPTH);
    localparam int CNT_W = TAG_W + 1;

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] done;
    rob_entry_t       entries [DEPTH];

    logic             head_valid;
    rob_entry_t       head_entry;
    logic             alloc_fire;
    logic             flush_fire;
    logic [TAG_W-1:0] flush_span;
    logic [DEPTH-1:0] younger;

    assign alloc_ready = (count != CNT_W'(DEPTH));
    assign alloc_tag   = tail;
    assign empty       = (count == '0);

    always_comb begin
        head_valid = valid[head];
        head_entry = entries[head];
        commit_en  = valid[head] & done[head];
        flush_fire = flush_valid & valid[flush_tag];
        alloc_fire = alloc_valid & alloc_ready & ~flush_valid;
        flush_span = flush_tag - head;
        // Age is measured as distance from head, so entries past the branch
        // in program order are exactly those with a larger distance.
        for (int i = 0; i < DEPTH; i++) begin
            younger[i] = (TAG_W'(i) - head) > flush_span;
        end
        commit_old_preg = '0;
        commit_prd      = '0;
        commit_rd       = '0;
        commit_regwrite = 1'b0;
        commit_pc       = '0;
        if (head_valid) begin
            commit_old_preg = head_entry.old_prd;
            commit_prd      = head_entry.prd;
            commit_rd       = head_entry.rd;
            commit_regwrite = head_entry.regwrite;
            commit_pc       = head_entry.pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (cmpl_valid && valid[cmpl_tag]) begin
                done[cmpl_tag] <= 1'b1;
            end
            // Flush clearing follows completion so a completion to a
            // squashed entry in the same cycle cannot survive.
            if (flush_fire) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (younger[i]) begin
                        valid[i] <= 1'b0;
                        done[i]  <= 1'b0;
                    end
                end
            end
            if (alloc_fire) begin
                entries[tail] <= '{pc: alloc_pc, rd: alloc_rd, prd: alloc_prd,
                                   old_prd: alloc_old_prd, regwrite: alloc_regwrite};
                valid[tail]   <= 1'b1;
                done[tail]    <= 1'b0;
            end
            if (commit_en) begin
                valid[head] <= 1'b0;
                head        <= head + TAG_W'(1);
            end
            if (flush_fire) begin
                tail  <= flush_tag + TAG_W'(1);
                count <= {1'b0, flush_span} + CNT_W'(1) - CNT_W'(commit_en);
            end else begin
                if (alloc_fire) begin
                    tail <= tail + TAG_W'(1);
                end
                count <= count + CNT_W'(alloc_fire) - CNT_W'(commit_en);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ============================================================================
// tb_reorder_buffer : directed and random checks of reorder_buffer against a
//                     queue-based program-order model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reorder_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       alloc_valid = 1'b0;
    logic       alloc_ready;
    logic [3:0] alloc_tag;
    logic [8:0] alloc_pc = '0;
    logic [4:0] alloc_rd = '0;
    logic [6:0] alloc_prd = '0;
    logic [6:0] alloc_old_prd = '0;
    logic       alloc_regwrite = 1'b0;
    logic       cmpl_valid = 1'b0;
    logic [3:0] cmpl_tag = '0;
    logic       flush_valid = 1'b0;
    logic [3:0] flush_tag = '0;
    logic       commit_en;
    logic [6:0] commit_old_preg;
    logic [6:0] commit_prd;
    logic [4:0] commit_rd;
    logic       commit_regwrite;
    logic [8:0] commit_pc;
    logic       empty;

    reorder_buffer #(.DEPTH(16), .PREG_W(7), .PC_W(9)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .alloc_pc(alloc_pc), .alloc_rd(alloc_rd), .alloc_prd(alloc_prd),
        .alloc_old_prd(alloc_old_prd), .alloc_regwrite(alloc_regwrite),
        .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .commit_en(commit_en), .commit_old_preg(commit_old_preg),
        .commit_prd(commit_prd), .commit_rd(commit_rd),
        .commit_regwrite(commit_regwrite), .commit_pc(commit_pc), .empty(empty)
    );

    always #5 clk = ~clk;

    // Program-order model: q[0] is the oldest in-flight instruction.
    typedef struct {
        int       tag;
        bit [8:0] pc;
        bit [4:0] rd;
        bit [6:0] prd;
        bit [6:0] old;
        bit       rw;
        bit       done;
    } ment_t;

    ment_t q[$];
    int    next_tag = 0;
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ctx);
        bit       has = (q.size() > 0);
        check({ctx, ".commit_en"}, 32'(commit_en), 32'(has && q[0].done));
        check({ctx, ".alloc_ready"}, 32'(alloc_ready), 32'(q.size() != 16));
        check({ctx, ".alloc_tag"}, 32'(alloc_tag), 32'(next_tag));
        check({ctx, ".empty"}, 32'(empty), 32'(q.size() == 0));
        check({ctx, ".commit_pc"}, 32'(commit_pc), has ? 32'(q[0].pc) : 0);
        check({ctx, ".commit_rd"}, 32'(commit_rd), has ? 32'(q[0].rd) : 0);
        check({ctx, ".commit_prd"}, 32'(commit_prd), has ? 32'(q[0].prd) : 0);
        check({ctx, ".commit_old"}, 32'(commit_old_preg), has ? 32'(q[0].old) : 0);
        check({ctx, ".commit_rw"}, 32'(commit_regwrite), has ? 32'(q[0].rw) : 0);
    endtask

    // One clock cycle: drive, check, advance the model, then return at negedge.
    task automatic step(input string ctx, input bit av, input bit cv, input int ct,
                        input bit fv, input int ft, input bit [6:0] old, input bit rw);
        bit    commit;
        int    fidx;
        ment_t e;
        alloc_valid    = av;
        alloc_pc       = 9'($urandom);
        alloc_rd       = 5'($urandom);
        alloc_prd      = 7'($urandom);
        alloc_old_prd  = old;
        alloc_regwrite = rw;
        cmpl_valid     = cv;
        cmpl_tag       = 4'(ct);
        flush_valid    = fv;
        flush_tag      = 4'(ft);
        #1;
        check_outputs(ctx);
        commit = (q.size() > 0) && q[0].done;
        fidx = -1;
        if (fv) foreach (q[i]) if (q[i].tag == ft) fidx = i;
        if (cv) foreach (q[i]) if (q[i].tag == ct) q[i].done = 1'b1;
        if (fidx >= 0) begin
            while (q.size() > fidx + 1) q.delete(q.size() - 1);
            next_tag = (ft + 1) % 16;
        end else if (av && !fv && q.size() < 16) begin
            e.tag = next_tag; e.pc = alloc_pc; e.rd = alloc_rd; e.prd = alloc_prd;
            e.old = old; e.rw = rw; e.done = 1'b0;
            q.push_back(e);
            next_tag = (next_tag + 1) % 16;
        end
        if (commit) q.delete(0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input string ctx);
        step(ctx, 0, 0, 0, 0, 0, 7'd0, 1'b0);
    endtask

    task automatic alloc(input string ctx);
        step(ctx, 1, 0, 0, 0, 0, 7'($urandom), 1'($urandom));
    endtask

    task automatic cmpl(input string ctx, input int t);
        step(ctx, 0, 1, t, 0, 0, 7'd0, 1'b0);
    endtask

    task automatic do_reset();
        alloc_valid = 1'b0; cmpl_valid = 1'b0; flush_valid = 1'b0;
        reset = 1'b0;
        q.delete();
        next_tag = 0;
        #1;
        check_outputs("reset_async");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int budget;
        @(negedge clk);
        do_reset();
        check_outputs("reset_state");

        // Basic retire with a known old_prd
        step("basic_alloc", 1, 0, 0, 0, 0, 7'd40, 1'b1);
        cmpl("basic_cmpl", 0);
        check("basic_commit_en", 32'(commit_en), 32'd1);
        check("basic_old_preg", 32'(commit_old_preg), 32'd40);
        idle("basic_retire");
        check("basic_empty", 32'(empty), 32'd1);

        // Out-of-order completion, in-order retirement
        do_reset();
        for (int i = 0; i < 3; i++) alloc("ooo_alloc");
        cmpl("ooo_c2", 2);
        cmpl("ooo_c1", 1);
        check("ooo_no_commit", 32'(commit_en), 32'd0);
        cmpl("ooo_c0", 0);
        for (int i = 0; i < 4; i++) idle("ooo_drain");

        // Full, then a commit frees a slot only from the following cycle
        do_reset();
        for (int i = 0; i < 16; i++) alloc("full_alloc");
        check("full_ready", 32'(alloc_ready), 32'd0);
        step("full_cmpl0", 1, 1, 0, 0, 0, 7'd1, 1'b1);
        check("full_commit", 32'(commit_en), 32'd1);
        check("full_ready_at_commit", 32'(alloc_ready), 32'd0);
        alloc("full_commit_cycle");
        check("full_wrap_ready", 32'(alloc_ready), 32'd1);
        check("full_wrap_tag", 32'(alloc_tag), 32'd0);
        alloc("full_wrap_alloc");
        check("full_again", 32'(alloc_ready), 32'd0);

        // Flush younger than tag 5 with head at 3
        do_reset();
        for (int i = 0; i < 10; i++) alloc("flush_alloc");
        for (int i = 0; i < 3; i++) cmpl("flush_pre", i);
        idle("flush_settle");
        step("flush_5", 0, 0, 0, 1, 5, 7'd0, 1'b0);
        check("flush_tail", 32'(alloc_tag), 32'd6);
        cmpl("flush_late8", 8);
        for (int i = 3; i < 10; i++) cmpl("flush_cmpl", i);
        for (int i = 0; i < 4; i++) idle("flush_drain");
        check("flush_empty", 32'(empty), 32'd1);

        // Flush at head coinciding with its commit
        do_reset();
        for (int i = 0; i < 8; i++) alloc("fh_alloc");
        for (int i = 0; i < 6; i++) cmpl("fh_cmpl", i);
        budget = 20;
        while (!(q.size() > 0 && q[0].tag == 5 && q[0].done) && budget > 0) begin
            idle("fh_wait");
            budget--;
        end
        check("fh_reached_head", 32'(budget > 0), 32'd1);
        step("fh_flush", 0, 0, 0, 1, 5, 7'd0, 1'b0);
        check("fh_empty", 32'(empty), 32'd1);
        check("fh_tag", 32'(alloc_tag), 32'd6);

        // Reset mid-operation must act without a clock edge
        for (int i = 0; i < 10; i++) alloc("mid_alloc");
        #2;
        do_reset();
        alloc("mid_first_alloc");
        check("mid_tag_after", 32'(alloc_tag), 32'd1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int  ct;
            bit  cv;
            bit  fv;
            int  ft;
            cv = ($urandom_range(0, 3) != 0);
            ct = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                 q[$urandom_range(0, q.size() - 1)].tag : int'($urandom_range(0, 15));
            fv = ($urandom_range(0, 31) == 0);
            ft = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                 q[$urandom_range(0, q.size() - 1)].tag : int'($urandom_range(0, 15));
            step("rand", 1'($urandom_range(0, 4) != 0), cv, ct, fv, ft,
                 7'($urandom), 1'($urandom));
            if (n == 1500) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement queue for the out-of-order core, sitting downstream of `rename`. It accepts one renamed instruction per cycle from dispatch and records completions broadcast by the execution units. It retires completed entries strictly in program order, driving the `commit_en` / `commit_old_preg` pair that returns freed physical registers to rename's free list. On a branch mispredict it flushes every entry younger than the mispredicted branch.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; must be a power of two. Tag width is `$clog2(DEPTH)` = 4.
- `PREG_W`, 7: physical register index width.
- `PC_W`, 9: PC width.

Ports:
- `clk`  in  1  clock; the block has one clock, and all state updates on its rising edge.
- `reset`  in  1  reset; asynchronous and active-low.
- `alloc_valid`  in  1  dispatch presents an instruction.
- `alloc_ready`  out  1  ROB can accept an entry; equals `count != DEPTH`.
- `alloc_tag`  out  4  tag the next allocation receives; equals `tail`.
- `alloc_pc`  in  PC_W  instruction PC.
- `alloc_rd`  in  5  architectural destination register.
- `alloc_prd`  in  PREG_W  new physical destination.
- `alloc_old_prd`  in  PREG_W  previous mapping of `rd`.
- `alloc_regwrite`  in  1  instruction writes `rd`.
- `cmpl_valid`  in  1  completion broadcast.
- `cmpl_tag`  in  4  tag of the completing entry.
- `flush_valid`  in  1  branch mispredict.
- `flush_tag`  in  4  tag of the mispredicted branch.
- `commit_en`  out  1  head entry retires this cycle.
- `commit_old_preg`  out  PREG_W  register to free; meaningful only when `commit_en && commit_regwrite`.
- `commit_prd`  out  PREG_W  head's physical destination.
- `commit_rd`  out  5  head's architectural destination.
- `commit_regwrite`  out  1  head writes a register.
- `commit_pc`  out  PC_W  head's PC.
- `empty`  out  1  `count == 0`.

## Operation
- **State.** The ROB holds `head`, `tail` (4-bit, wrapping at DEPTH), a 5-bit `count`, and per-entry `valid`, `done` and payload.
- **Allocate.** An allocation fires when `alloc_valid && alloc_ready && !flush_valid`.
  - Entry[tail] gets its payload, `valid`=1 and `done`=0.
  - `tail` increments.
- **Complete.** When `cmpl_valid` is high and `valid[cmpl_tag]` is set, `done[cmpl_tag]` is set to 1.
  - A completion to an invalid entry is ignored.
  - This includes the tag being allocated in the same cycle.
- **Commit.** `commit_en = valid[head] && done[head]`, combinational from registered state.
  - On commit, `valid[head]` is cleared and `head` increments.
  - At most one commit per cycle.
  - The commit outputs carry entry[head] payload whenever `valid[head]`; otherwise they are 0.
- **Flush.** A flush takes effect when `flush_valid` is high and `valid[flush_tag]` is set; otherwise it is ignored.
  - Every entry strictly younger than `flush_tag` (from `flush_tag+1` up to `tail-1`, mod DEPTH) has `valid` and `done` cleared.
  - `tail` is set to `flush_tag+1`.
  - Allocation is suppressed in the flush cycle; `alloc_ready` still reflects count.
  - The flushed branch itself stays and commits normally.
- **Count update.**
  - Without a flush: `count += alloc_fire - commit_en`.
  - With a flush: `count = ((flush_tag - head) mod DEPTH) + 1 - commit_en`.
- **Full.** When `count == 16`, `alloc_ready`=0. A commit in that cycle does not enable an allocation in the same cycle; it takes effect from the next cycle.
- **Empty.** When `count == 0`, `commit_en`=0.
- **Wrap-around.** `head` and `tail` wrap 15→0. When `head == tail`, `count` disambiguates empty from full.
- **Reset.** Reset may be asserted mid-operation. It asynchronously clears all entries, pointers and count.
  - After reset: `alloc_ready`=1, `alloc_tag`=0, `empty`=1, and every `commit_*` output is 0.

## Timing
- **Allocate to commit.**
  - An entry allocated at edge N is visible at head at the earliest from cycle N+1.
  - A completion sampled at edge N makes `commit_en` high at the earliest in cycle N+1.
  - Minimum allocate→commit is 2 edges.
- **Commit handshake.** `commit_en` is a single-cycle strobe per entry. Rename must consume it in the same cycle; there is no backpressure on commit.
- **Simultaneous events.**
  - Allocate, complete, commit and flush may all occur in one cycle and resolve per the rules above.
  - If `flush_tag == head` with commit in the same cycle, the ROB is empty afterwards.
- **Throughput.** One allocation and one commit per cycle, sustained.

## Structure
- Shared package `ooo_pkg`:
  - `ROB_DEPTH`, `ROB_TAG_W`, `PREG_W`, `PC_W`.
  - `rob_tag_t`.
  - `rob_entry_t`, a packed struct of `pc`, `rd`, `prd`, `old_prd`, `regwrite`.
- `rename` and `OoO_top` import the same package.
- Single module; no sub-module is warranted. The entry array is flops, since `valid`/`done` need bulk clear on flush.

## Test plan
- **Reset and basic retire.** Reset, then allocate tag 0 with `old_prd`=7'd40 and `regwrite`=1, then complete tag 0. Required: `commit_en` is high one cycle after the completion with `commit_old_preg`=40, then `empty`=1.
- **Out-of-order completion.** Allocate tags 0–2, then complete in order 2, 1, 0. Required: no commit until tag 0 completes, then three consecutive `commit_en` cycles in order 0, 1, 2.
- **Full and commit.** Allocate 16 entries. Required: `alloc_ready`=0. Then complete tag 0 while holding `alloc_valid`=1. Required: one commit occurs, the allocation is accepted the next cycle with `alloc_tag`=0 (wrap), and count is 16 again.
- **Flush.** With tags 3–9 valid and head=3, assert a flush with `flush_tag`=5. Required: `tail`=6, count=3, and tags 6–9 are never committed. A late completion to tag 8 is ignored.
- **Flush at head with commit.** Head=5, done, and `flush_tag`=5 in the same cycle. Required: commit of tag 5, then `empty`=1, `alloc_tag`=6.
- **Reset mid-operation.** Assert `reset` low with 10 entries valid. Required: outputs reach their reset values immediately, without waiting for a clock edge, and the first allocation after release gets tag 0.
